// File: rtl/slave_serial_rx_if.sv
// Host/loader-facing signal bundle for the slave-serial receiver.
// slave modport is the receiver side, master modport is the host/loader side.
// With SSRX_CHECKSUM_EN defined the bundle also carries checksum[7:0].
interface slave_serial_rx_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             bl_clk;
  logic             bl_data;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             sync_found;
  logic             frame_err;
  logic [CNT_W-1:0] byte_count;
  logic [1:0]       state_dbg;
  logic [2:0]       bit_cnt_debug;
`ifdef SSRX_CHECKSUM_EN
  logic [7:0]       checksum;
`endif

  modport slave (
    input  enable,
    input  bl_clk,
    input  bl_data,
    output byte_data,
    output byte_valid,
    output sync_found,
    output frame_err,
    output byte_count,
    output state_dbg,
    output bit_cnt_debug
`ifdef SSRX_CHECKSUM_EN
    , output checksum
`endif
  );

  modport master (
    output enable,
    output bl_clk,
    output bl_data,
    input  byte_data,
    input  byte_valid,
    input  sync_found,
    input  frame_err,
    input  byte_count,
    input  state_dbg,
    input  bit_cnt_debug
`ifdef SSRX_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/slave_serial_rx.sv
// Oversampling slave-serial receiver: hunts for SYNC_WORD, then emits MSB-first payload bytes.
// Latency: bl_clk pin rise to byte_valid is SYNC_STAGES+2 clk cycles.
// No backpressure: byte_valid is a one-cycle strobe. Optional SSRX_CHECKSUM_EN adds an XOR checksum output.
module slave_serial_rx #(
  parameter logic [31:0] SYNC_WORD   = 32'hAA995566,
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 16,
  parameter int          TIMEOUT     = 1024
) (
  input logic              clk,
  input logic              rst,
  slave_serial_rx_if.slave bus
);
  localparam int                GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0]  TIMEOUT_V = GAP_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HUNT    = 2'b01,
    ALIGNED = 2'b10,
    ERROR   = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync, bdat_sync;
  logic                   bclk_prev, rise_q, dat_q;
  // The newest bit (dat_q) completes the 32-bit hunt window and the 8-bit byte,
  // so only the older 31 / 7 bits need storage.
  logic [30:0]            hunt_q;
  logic [6:0]             byte_sr;
  logic [2:0]             bit_cnt;
  logic [CNT_W-1:0]       byte_count_q;
  logic [7:0]             byte_data_q;
  logic                   byte_valid_q;
  logic [GAP_W-1:0]       gap_cnt;
  logic [31:0]            hunt_win;
  logic [7:0]             new_byte;
  logic                   sync_hit, gap_expired;
`ifdef SSRX_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  assign hunt_win    = {hunt_q, dat_q};
  assign new_byte    = {byte_sr, dat_q};
  assign sync_hit    = rise_q && (hunt_win == SYNC_WORD);
  assign gap_expired = (gap_cnt >= TIMEOUT_V);

  // Synchronize bl_clk/bl_data at equal depth, then register the rising-edge pulse with its data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      bdat_sync <= '0;
      bclk_prev <= 1'b0;
      rise_q    <= 1'b0;
      dat_q     <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.bl_clk};
      bdat_sync <= {bdat_sync[SYNC_STAGES-2:0], bus.bl_data};
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      rise_q    <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
      dat_q     <= bdat_sync[SYNC_STAGES-1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: enable low dominates everything, ERROR is only left through IDLE.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = HUNT;
        HUNT:    if (sync_hit) state_d = ALIGNED;
        ALIGNED: if (gap_expired) state_d = ERROR;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift/assemble datapath, byte strobe, saturating count and mid-byte gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hunt_q       <= '0;
      byte_sr      <= '0;
      bit_cnt      <= '0;
      byte_count_q <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      gap_cnt      <= '0;
`ifdef SSRX_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else if (!bus.enable) begin
      // byte_data deliberately holds so the host can still read the last byte.
      hunt_q       <= '0;
      byte_sr      <= '0;
      bit_cnt      <= '0;
      byte_count_q <= '0;
      byte_valid_q <= 1'b0;
      gap_cnt      <= '0;
`ifdef SSRX_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      if (state_q == ALIGNED && !rise_q && bit_cnt != 3'd0) gap_cnt <= gap_cnt + 1'b1;
      else                                                 gap_cnt <= '0;
      if (state_q == HUNT && rise_q) begin
        hunt_q  <= hunt_win[30:0];
        byte_sr <= new_byte[6:0];
        if (sync_hit) begin
          bit_cnt      <= '0;
          byte_count_q <= '0;
`ifdef SSRX_CHECKSUM_EN
          csum_q       <= '0;
`endif
        end
      end else if (state_q == ALIGNED && rise_q) begin
        hunt_q  <= hunt_win[30:0];
        byte_sr <= new_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data_q  <= new_byte;
          byte_valid_q <= 1'b1;
          if (byte_count_q != '1) byte_count_q <= byte_count_q + 1'b1;
`ifdef SSRX_CHECKSUM_EN
          csum_q       <= csum_q ^ new_byte;
`endif
        end
      end
    end
  end

  assign bus.byte_data     = byte_data_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.sync_found    = (state_q == ALIGNED);
  assign bus.frame_err     = (state_q == ERROR);
  assign bus.byte_count    = byte_count_q;
  assign bus.state_dbg     = state_q;
  assign bus.bit_cnt_debug = bit_cnt;
`ifdef SSRX_CHECKSUM_EN
  assign bus.checksum      = csum_q;
`endif
endmodule

// File: tb/tb_slave_serial_rx.sv
// Directed bench for slave_serial_rx with a bit-level behavioural model and a per-cycle strobe checker.
// Loader bl_clk period is 32 clk; the receiver is built with CNT_W=4 so saturation is reachable.
// Checksum is checked too when SSRX_CHECKSUM_EN is defined.
module tb_slave_serial_rx;
  localparam int          CNT_W   = 4;
  localparam int          TIMEOUT = 1024;
  localparam logic [31:0] SYNC    = 32'hAA995566;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slave_serial_rx_if #(.CNT_W(CNT_W)) bus();
  slave_serial_rx #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (one step per loader bit) ----------------
  typedef struct {
    logic [7:0] dat;
    int         cnt;
    logic [7:0] csum;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  seen[$];
  bit          m_en;
  logic [31:0] m_win;
  bit          m_aligned, m_err;
  int          m_nbits, m_count;
  logic [7:0]  m_byte, m_csum;

  function automatic void m_reset();
    m_win = 0; m_aligned = 0; m_err = 0; m_nbits = 0; m_count = 0; m_byte = 0; m_csum = 0;
  endfunction

  function automatic void m_bit(input bit b);
    exp_t e;
    if (!m_en || m_err) return;
    if (!m_aligned) begin
      m_win = {m_win[30:0], b};
      if (m_win == SYNC) begin
        m_aligned = 1; m_nbits = 0; m_count = 0; m_csum = 0;
      end
    end else begin
      m_byte = {m_byte[6:0], b};
      m_nbits++;
      if (m_nbits == 8) begin
        m_nbits = 0;
        if (m_count < (1 << CNT_W) - 1) m_count++;
        m_csum = m_csum ^ m_byte;
        e.dat = m_byte; e.cnt = m_count; e.csum = m_csum;
        expq.push_back(e);
      end
    end
  endfunction

  // A stall of this many clk cycles with no loader edge.
  function automatic void m_stall(input int cycles);
    if (m_en && m_aligned && m_nbits != 0 && cycles >= TIMEOUT) begin
      m_err = 1; m_aligned = 0;
    end
  endfunction

  // Every strobe must match the next modelled byte; any strobe not modelled is an error.
  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.byte_valid === 1'b1) begin
      exp_t e;
      seen.push_back(bus.byte_data);
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got byte_data=%0h, no byte expected", bus.byte_data);
      end else begin
        e = expq.pop_front();
        chk("stream_byte", bus.byte_data, e.dat);
        chk("stream_count", bus.byte_count, e.cnt);
`ifdef SSRX_CHECKSUM_EN
        chk("stream_checksum", bus.checksum, e.csum);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input bit b, output int lat);
    lat = 0;
    bus.bl_data = b;
    repeat (16) @(negedge clk);
    bus.bl_clk = 1'b1;
    m_bit(b);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (lat == 0 && bus.byte_valid === 1'b1) lat = i;
    end
    bus.bl_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output int lat);
    int l;
    lat = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], l);
      lat = l;
    end
  endtask

  task automatic send_sync();
    int l;
    send_byte(8'hAA, l); send_byte(8'h99, l); send_byte(8'h55, l); send_byte(8'h66, l);
  endtask

  // One-cycle enable drop: receiver must be back in IDLE with everything cleared.
  task automatic en_pulse();
    chk("leftover_expected", expq.size(), 0);
    @(negedge clk);
    bus.enable = 1'b0; m_en = 0; m_reset();
    @(negedge clk);
    chk("enoff_state", bus.state_dbg, 2'b00);
    chk("enoff_frame_err", bus.frame_err, 1'b0);
    chk("enoff_count", bus.byte_count, 0);
    chk("enoff_sync", bus.sync_found, 1'b0);
    bus.enable = 1'b1; m_en = 1;
    @(negedge clk);
    chk("enon_hunt", bus.state_dbg, 2'b01);
    seen.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    rst = 1'b1; bus.enable = 1'b0; bus.bl_clk = 1'b0; bus.bl_data = 1'b0;
    m_en = 0; m_reset();
    #12;
    chk("rst_byte_data", bus.byte_data, 8'h00);
    chk("rst_valid", bus.byte_valid, 1'b0);
    chk("rst_sync", bus.sync_found, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_count", bus.byte_count, 0);
    chk("rst_state", bus.state_dbg, 2'b00);
    chk("rst_bitcnt", bus.bit_cnt_debug, 3'd0);
`ifdef SSRX_CHECKSUM_EN
    chk("rst_checksum", bus.checksum, 8'h00);
`endif
    @(negedge clk); rst = 1'b0;
    bus.enable = 1'b1; m_en = 1;
    @(negedge clk);
    chk("hunt_after_enable", bus.state_dbg, 2'b01);

    // Sync then two payload bytes.
    send_byte(8'hFF, l); send_byte(8'hFF, l);
    send_byte(8'hAA, l); send_byte(8'h99, l); send_byte(8'h55, l);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h66 >> i), l);
    chk("sync_before_last_bit", bus.sync_found, 1'b0);
    send_bit(1'b0, l);
    chk("sync_after_last_bit", bus.sync_found, 1'b1);
    chk("aligned_state", bus.state_dbg, 2'b10);
    send_byte(8'h12, l);
    send_byte(8'h34, l);
    chk("pin_to_valid_latency", l, 4);
    chk("two_bytes_count", bus.byte_count, 2);
    chk("two_bytes_seen", seen.size(), 2);
    chk("first_byte", seen[0], 8'h12);
    chk("second_byte", seen[1], 8'h34);
`ifdef SSRX_CHECKSUM_EN
    chk("checksum_12_34", bus.checksum, 8'h26);
`endif

    // Reset mid-byte, then release with enable low while the loader keeps clocking.
    send_bit(1'b1, l); send_bit(1'b1, l); send_bit(1'b0, l);
    @(negedge clk); #3 rst = 1'b1;
    m_en = 0; m_reset(); bus.enable = 1'b0;
    #1;
    chk("midrst_state", bus.state_dbg, 2'b00);
    chk("midrst_sync", bus.sync_found, 1'b0);
    chk("midrst_count", bus.byte_count, 0);
    chk("midrst_bitcnt", bus.bit_cnt_debug, 3'd0);
    chk("midrst_byte_data", bus.byte_data, 8'h00);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(i[0], l);
    chk("idle_hold_state", bus.state_dbg, 2'b00);
    chk("idle_hold_bitcnt", bus.bit_cnt_debug, 3'd0);
    bus.enable = 1'b1; m_en = 1;
    @(negedge clk);
    seen.delete();

    // Junk bits ahead of the sync word.
    send_bit(1'b1, l); send_bit(1'b0, l); send_bit(1'b1, l);
    send_sync();
    chk("junk_sync", bus.sync_found, 1'b1);
    send_byte(8'hA5, l);
    chk("junk_byte", seen.size() > 0 ? seen[0] : 8'hxx, 8'hA5);
    chk("junk_count", bus.byte_count, 1);

    // Mid-byte stall -> ERROR; edges in ERROR are ignored.
    en_pulse();
    send_sync();
    send_bit(1'b1, l); send_bit(1'b0, l); send_bit(1'b1, l);
    chk("partial_bitcnt", bus.bit_cnt_debug, 3'd3);
    chk("partial_no_err", bus.frame_err, 1'b0);
    m_stall(1100);
    repeat (1100) @(negedge clk);
    chk("timeout_err", bus.frame_err, m_err);
    chk("timeout_err_lit", bus.frame_err, 1'b1);
    chk("timeout_state", bus.state_dbg, 2'b11);
    chk("timeout_sync_low", bus.sync_found, 1'b0);
    send_byte(8'hFF, l);
    chk("error_sticky", bus.state_dbg, 2'b11);
    en_pulse();

    // Long gap at a byte boundary is legal.
    send_sync();
    send_byte(8'h5A, l);
    m_stall(5000);
    repeat (5000) @(negedge clk);
    send_byte(8'hC3, l);
    chk("gap_no_err", bus.frame_err, m_err);
    chk("gap_count", bus.byte_count, 2);
    chk("gap_state", bus.state_dbg, 2'b10);

    // Saturation, then enable dropped on the 8th bit's processing cycle.
    en_pulse();
    send_sync();
    for (int i = 0; i < 20; i++) send_byte(8'(i * 13 + 7), l);
    chk("sat_count_lit", bus.byte_count, 15);
    chk("sat_count_model", bus.byte_count, m_count);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i), l);
    bus.bl_data = 1'b0;
    repeat (16) @(negedge clk);
    bus.bl_clk = 1'b1;
    repeat (3) @(negedge clk);
    bus.enable = 1'b0; m_en = 0; m_reset();
    @(negedge clk);
    chk("abort_state", bus.state_dbg, 2'b00);
    chk("abort_count", bus.byte_count, 0);
    bus.enable = 1'b1; m_en = 1;
    repeat (12) @(negedge clk);
    bus.bl_clk = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_pending", expq.size(), 0);
    chk("abort_rehunt", bus.state_dbg, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
